dsp_post_adder_acc: RTL and testbench
=====================================

Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1-style slice, directly downstream of the M (multiplier) register/mux stage.
- Selects X and Z operands by OPMODE, adds or subtracts them with carry-in, and registers the result into the P accumulator.
- Produces CARRYOUT and PCOUT for cascade to the next slice.

Parameters:
- OPMODEREG, 1, 1 = OPMODE passes through an internal CE-gated register; 0 = combinational.
- CARRYINREG, 1, 1 = selected carry-in passes through a register; 0 = combinational.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" uses OPMODE[5], "CARRYIN" uses the CARRYIN port.

Ports:
- clk  in  1  single clock; all registers rise on posedge.
- rst  in  1  asynchronous, active-low reset of all registers in the block.
- CEOPMODE  in  1  clock enable, OPMODE register.
- CECARRYIN  in  1  clock enable, carry-in register.
- CEP  in  1  clock enable, P and CARRYOUT registers.
- OPMODE  in  8  [1:0] X select, [3:2] Z select, [5] carry-in, [7] 1 = subtract; bits 4 and 6 ignored.
- CARRYIN  in  1  external carry-in.
- M  in  36  multiplier result from the M stage.
- C  in  48  C operand.
- DAB  in  48  concatenated D[11:0]:A[17:0]:B[17:0].
- PCIN  in  48  cascade input from the previous slice.
- P  out  48  registered accumulator result.
- PCOUT  out  48  identical copy of P.
- CARRYOUT  out  1  registered post-adder carry/borrow.
- CARRYOUTF  out  1  identical copy of CARRYOUT.

Behaviour:
- Reset (rst = 0, asynchronous): P, CARRYOUT, the OPMODE register and the carry-in register all go to 0 immediately. They hold 0 until the first posedge after rst = 1.
- X mux, OPMODE[1:0]:
  - 00 → 0
  - 01 → M zero-extended to 48 bits
  - 10 → P (accumulator feedback)
  - 11 → DAB
- Z mux, OPMODE[3:2]:
  - 00 → 0
  - 01 → PCIN
  - 10 → P
  - 11 → C
- Carry-in (CIN) is OPMODE[5] or CARRYIN, per CARRYINSEL. It is registered when CARRYINREG = 1.
- Arithmetic, 49-bit internal, result R:
  - Add (OPMODE[7] = 0): R = {0,Z} + {0,X} + CIN.
  - Subtract (OPMODE[7] = 1): R = {0,Z} − ({0,X} + CIN).
  - P ← R[47:0] and CARRYOUT ← R[48]. CARRYOUT is carry on add and borrow on subtract.
  - Wrap-around is modulo 2^48; there is no saturation.
- Latency:
  - Data inputs (M, C, DAB, PCIN, CARRYIN) are sampled at edge n and appear on P at edge n.
  - Registered OPMODE/CIN add one cycle on the control path: OPMODE applied before edge n−1 governs the sum captured at edge n.
  - With OPMODEREG = 0 and CARRYINREG = 0, everything takes effect at the next edge.
- CE behaviour:
  - CEP = 0 holds P and CARRYOUT. Feedback modes then keep P constant.
  - CEOPMODE = 0 holds the registered OPMODE.
  - CECARRYIN = 0 holds the registered CIN.
- Feedback with CEP = 1: P ← P ± X every cycle. This accumulates.
- Simultaneous X = P and Z = P selects are legal; the result is 2P + CIN.
- Reset asserted mid-accumulation clears immediately. The accumulation restarts from 0 after release.

Optional Feature:
- Macro: DSP_POSTADD_OVF_EN.
- Defined: adds output OVERFLOW (1 bit), registered with P under CEP and cleared by reset. It is set when the signed two's-complement result overflows: operands treated as signed 48-bit, sign of result differs from the expected sign.
- Undefined: the port and its logic are absent.

Decomposition:
- Package dsp48_pkg holds:
  - width localparams P_W = 48 and M_W = 36
  - X select encodings: X_ZERO, X_M, X_P, X_DAB
  - Z select encodings: Z_ZERO, Z_PCIN, Z_P, Z_C
  - OPMODE bit-index constants: OP_SUB = 7, OP_CIN = 5
- Sub-module dsp_pipe_reg: parameterised-width register with CE and asynchronous active-low clear, plus a bypass parameter. Instantiate it for OPMODE, CIN, P and CARRYOUT.

Test Plan:
- Reset: rst = 0 with P previously 0x123 → P = 0, CARRYOUT = 0 immediately, without waiting for a clock edge.
- Multiply-add, registers bypassed: OPMODE = 0x0D (X = M, Z = C), M = 5, C = 10, CIN = 0 → P = 15 after one edge.
- Accumulate: OPMODE = 0x09 (X = M, Z = P), M = 3 held for 4 edges from P = 0 → P = 3, 6, 9, 12. Then CEP = 0 for 2 edges → P stays 12.
- Subtract with borrow: OPMODE = 0x8D, C = 2, M = 5 → P = 0xFFFF_FFFF_FFFD, CARRYOUT = 1.
- Carry wrap: OPMODE = 0x2F (X = DAB, Z = C, CIN = 1), DAB = 0xFFFF_FFFF_FFFF, C = 0 → P = 0, CARRYOUT = 1.
- OPMODEREG = 1 latency: switch OPMODE from 0x0D to 0x01 at edge k → P reflects Z = 0 starting at edge k+2, not k+1.

Source files
------------

// File: rtl/dsp48_pkg.sv
// Shared widths, operand-select encodings and OPMODE bit positions for the
// DSP48A1-style post-adder/accumulator slice.
package dsp48_pkg;

  localparam int unsigned P_W = 48;
  localparam int unsigned M_W = 36;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;

  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

  localparam int unsigned OP_SUB = 7;
  localparam int unsigned OP_CIN = 5;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// Operand, control and result bundle of the post-adder/accumulator slice.
// OVERFLOW exists only when DSP_POSTADD_OVF_EN is defined.
interface dsp_post_adder_acc_if;

  logic                          CEOPMODE;
  logic                          CECARRYIN;
  logic                          CEP;
  logic [7:0]                    OPMODE;
  logic                          CARRYIN;
  logic [dsp48_pkg::M_W-1:0]     M;
  logic [dsp48_pkg::P_W-1:0]     C;
  logic [dsp48_pkg::P_W-1:0]     DAB;
  logic [dsp48_pkg::P_W-1:0]     PCIN;
  logic [dsp48_pkg::P_W-1:0]     P;
  logic [dsp48_pkg::P_W-1:0]     PCOUT;
  logic                          CARRYOUT;
  logic                          CARRYOUTF;
`ifdef DSP_POSTADD_OVF_EN
  logic                          OVERFLOW;
`endif

  modport master (
    output CEOPMODE, CECARRYIN, CEP, OPMODE, CARRYIN, M, C, DAB, PCIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF
`ifdef DSP_POSTADD_OVF_EN
    , input OVERFLOW
`endif
  );

  modport slave (
    input  CEOPMODE, CECARRYIN, CEP, OPMODE, CARRYIN, M, C, DAB, PCIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF
`ifdef DSP_POSTADD_OVF_EN
    , output OVERFLOW
`endif
  );

endinterface

// File: rtl/dsp_pipe_reg.sv
// CE-gated pipeline register with asynchronous active-low clear; Bypass turns
// it into a plain wire so optional pipeline stages share one primitive.
module dsp_pipe_reg #(
  parameter int unsigned Width  = 1,
  parameter bit          Bypass = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Bypass) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce_i};
    assign q_o = d_i;
  end else begin : g_reg
    logic [Width-1:0] q_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q_q <= '0;
      end else if (ce_i) begin
        q_q <= d_i;
      end
    end
    assign q_o = q_q;
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator: X/Z operand muxes, add/subtract with carry-in, P and
// CARRYOUT registers. Define DSP_POSTADD_OVF_EN to add the signed OVERFLOW flag.
module dsp_post_adder_acc
  import dsp48_pkg::*;
#(
  parameter int unsigned OPMODEREG  = 1,
  parameter int unsigned CARRYINREG = 1,
  parameter string       CARRYINSEL = "OPMODE5"
) (
  input  logic                clk,
  input  logic                rst,
  dsp_post_adder_acc_if.slave bus
);

  localparam bit UseCarryinPort = (CARRYINSEL == "CARRYIN");

  logic [7:0]     opmode_q;
  logic           cin_src;
  logic           cin_q;
  logic [P_W-1:0] x_mux;
  logic [P_W-1:0] z_mux;
  logic [P_W:0]   sum;
  logic [P_W-1:0] p_q;
  logic           carry_q;
  logic           unused_opmode;

  // Carry-in source is taken from the raw input so that, like OPMODE, it
  // costs exactly one cycle when registered.
  assign cin_src = UseCarryinPort ? bus.CARRYIN : bus.OPMODE[OP_CIN];
  assign unused_opmode = opmode_q[6] ^ opmode_q[4];

  dsp_pipe_reg #(.Width(8), .Bypass(OPMODEREG == 0)) u_opmode_reg (
    .clk  (clk),
    .rst  (rst),
    .ce_i (bus.CEOPMODE),
    .d_i  (bus.OPMODE),
    .q_o  (opmode_q)
  );

  dsp_pipe_reg #(.Width(1), .Bypass(CARRYINREG == 0)) u_cin_reg (
    .clk  (clk),
    .rst  (rst),
    .ce_i (bus.CECARRYIN),
    .d_i  (cin_src),
    .q_o  (cin_q)
  );

  always_comb begin
    x_mux = '0;
    case (opmode_q[1:0])
      X_ZERO: x_mux = '0;
      X_M:    x_mux = {{(P_W-M_W){1'b0}}, bus.M};
      X_P:    x_mux = p_q;
      X_DAB:  x_mux = bus.DAB;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opmode_q[3:2])
      Z_ZERO: z_mux = '0;
      Z_PCIN: z_mux = bus.PCIN;
      Z_P:    z_mux = p_q;
      Z_C:    z_mux = bus.C;
    endcase
  end

  // Bit 48 is carry on add and borrow on subtract.
  always_comb begin
    if (opmode_q[OP_SUB]) begin
      sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_q});
    end else begin
      sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_q};
    end
  end

  dsp_pipe_reg #(.Width(P_W), .Bypass(1'b0)) u_p_reg (
    .clk  (clk),
    .rst  (rst),
    .ce_i (bus.CEP),
    .d_i  (sum[P_W-1:0]),
    .q_o  (p_q)
  );

  dsp_pipe_reg #(.Width(1), .Bypass(1'b0)) u_carry_reg (
    .clk  (clk),
    .rst  (rst),
    .ce_i (bus.CEP),
    .d_i  (sum[P_W]),
    .q_o  (carry_q)
  );

  assign bus.P         = p_q;
  assign bus.PCOUT     = p_q;
  assign bus.CARRYOUT  = carry_q;
  assign bus.CARRYOUTF = carry_q;

`ifdef DSP_POSTADD_OVF_EN
  logic [P_W+1:0] sres;
  logic           ovf_d;
  logic           ovf_q;

  // Two guard bits hold the exact signed result; overflow when it leaves 48-bit range.
  always_comb begin
    if (opmode_q[OP_SUB]) begin
      sres = {{2{z_mux[P_W-1]}}, z_mux} - {{2{x_mux[P_W-1]}}, x_mux}
             - {{(P_W+1){1'b0}}, cin_q};
    end else begin
      sres = {{2{z_mux[P_W-1]}}, z_mux} + {{2{x_mux[P_W-1]}}, x_mux}
             + {{(P_W+1){1'b0}}, cin_q};
    end
    ovf_d = (sres[P_W+1] != sres[P_W-1]) || (sres[P_W] != sres[P_W-1]);
  end

  dsp_pipe_reg #(.Width(1), .Bypass(1'b0)) u_ovf_reg (
    .clk  (clk),
    .rst  (rst),
    .ce_i (bus.CEP),
    .d_i  (ovf_d),
    .q_o  (ovf_q)
  );

  assign bus.OVERFLOW = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scoreboard bench: one slice with OPMODE/CIN bypassed (CIN = OPMODE[5]) and one
// with both registered (CIN = CARRYIN port).
module tb_dsp_post_adder_acc;

  typedef struct packed {
    logic [47:0] p;
    logic        co;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsp_post_adder_acc_if bb ();
  dsp_post_adder_acc_if rb ();

  dsp_post_adder_acc #(.OPMODEREG(0), .CARRYINREG(0), .CARRYINSEL("OPMODE5")) u_byp (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  dsp_post_adder_acc #(.OPMODEREG(1), .CARRYINREG(1), .CARRYINSEL("CARRYIN")) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (rb)
  );

  exp_t q_byp[$];
  exp_t q_reg[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference arithmetic in 64-bit integers; result is the 49-bit {carry, P}.
  function automatic logic [48:0] model(input logic [7:0] op, input logic [35:0] m,
                                        input logic [47:0] c, input logic [47:0] dab,
                                        input logic [47:0] pcin, input logic [47:0] p,
                                        input logic cin);
    longint unsigned xv, zv, r;
    case (op[1:0])
      2'd0: xv = 0;
      2'd1: xv = {28'b0, m};
      2'd2: xv = {16'b0, p};
      default: xv = {16'b0, dab};
    endcase
    case (op[3:2])
      2'd0: zv = 0;
      2'd1: zv = {16'b0, pcin};
      2'd2: zv = {16'b0, p};
      default: zv = {16'b0, c};
    endcase
    if (op[7]) r = zv - xv - {63'b0, cin};
    else       r = zv + xv + {63'b0, cin};
    return r[48:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    bb.CEOPMODE = 1; bb.CECARRYIN = 1; bb.CEP = 1; bb.OPMODE = 0; bb.CARRYIN = 0;
    bb.M = 0; bb.C = 0; bb.DAB = 0; bb.PCIN = 0;
    rb.CEOPMODE = 1; rb.CECARRYIN = 1; rb.CEP = 1; rb.OPMODE = 0; rb.CARRYIN = 0;
    rb.M = 0; rb.C = 0; rb.DAB = 0; rb.PCIN = 0;
    tick();
    tick();
    n_checks++;
    if (bb.P !== 48'h0 || bb.CARRYOUT !== 1'b0 || bb.PCOUT !== 48'h0)
      $display("FAIL reset_byp: P=%h CO=%b, expected P=0 CO=0", bb.P, bb.CARRYOUT);
    else n_pass++;
    n_checks++;
    if (rb.P !== 48'h0 || rb.CARRYOUT !== 1'b0 || rb.CARRYOUTF !== 1'b0)
      $display("FAIL reset_reg: P=%h CO=%b, expected P=0 CO=0", rb.P, rb.CARRYOUT);
    else n_pass++;
    rst = 1'b1;
    bb.OPMODE = 8'h0C; bb.C = 48'h123;
    q_byp.push_back('{p: 48'h123, co: 1'b0});
    tick();
    e = q_byp.pop_front();
    n_checks++;
    if (bb.P !== e.p || bb.CARRYOUT !== e.co)
      $display("FAIL preload: P=%h CO=%b, expected P=%h CO=%b", bb.P, bb.CARRYOUT, e.p, e.co);
    else n_pass++;
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (bb.P !== 48'h0 || bb.CARRYOUT !== 1'b0)
      $display("FAIL async_clear: P=%h CO=%b, expected P=0 CO=0", bb.P, bb.CARRYOUT);
    else n_pass++;
    tick();
    n_checks++;
    if (bb.P !== 48'h0)
      $display("FAIL reset_hold: P=%h, expected 0", bb.P);
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_mul_add;
    exp_t e;
    bb.OPMODE = 8'h0D; bb.M = 36'd5; bb.C = 48'd10;
    q_byp.push_back('{p: 48'd15, co: 1'b0});
    tick();
    e = q_byp.pop_front();
    n_checks++;
    if (bb.P !== e.p || bb.PCOUT !== e.p || bb.CARRYOUT !== e.co || bb.CARRYOUTF !== e.co)
      $display("FAIL mul_add: P=%h PCOUT=%h CO=%b, expected P=%h CO=%b",
               bb.P, bb.PCOUT, bb.CARRYOUT, e.p, e.co);
    else n_pass++;
  endtask

  task automatic test_accumulate;
    exp_t e;
    bb.OPMODE = 8'h00;
    q_byp.push_back('{p: 48'd0, co: 1'b0});
    tick();
    e = q_byp.pop_front();
    n_checks++;
    if (bb.P !== e.p) $display("FAIL acc_clear: P=%h, expected %h", bb.P, e.p);
    else n_pass++;
    bb.OPMODE = 8'h09; bb.M = 36'd3;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        bb.CEP = 1'b0;
        bb.M = 36'd100;
      end
      q_byp.push_back('{p: 48'(3 * ((i < 4) ? i + 1 : 4)), co: 1'b0});
      tick();
      e = q_byp.pop_front();
      n_checks++;
      if (bb.P !== e.p || bb.CARRYOUT !== e.co)
        $display("FAIL accumulate[%0d]: P=%h CO=%b, expected P=%h CO=%b",
                 i, bb.P, bb.CARRYOUT, e.p, e.co);
      else n_pass++;
    end
    bb.CEP = 1'b1; bb.M = 36'd3;
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (bb.P !== 48'h0) $display("FAIL acc_mid_reset: P=%h, expected 0", bb.P);
    else n_pass++;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_byp.push_back('{p: 48'(3 * (i + 1)), co: 1'b0});
      tick();
      e = q_byp.pop_front();
      n_checks++;
      if (bb.P !== e.p) $display("FAIL acc_restart[%0d]: P=%h, expected %h", i, bb.P, e.p);
      else n_pass++;
    end
  endtask

  task automatic test_subtract;
    exp_t e;
    bb.OPMODE = 8'h8D; bb.C = 48'd2; bb.M = 36'd5;
    q_byp.push_back('{p: 48'hFFFF_FFFF_FFFD, co: 1'b1});
    tick();
    e = q_byp.pop_front();
    n_checks++;
    if (bb.P !== e.p || bb.CARRYOUT !== e.co || bb.CARRYOUTF !== e.co)
      $display("FAIL subtract: P=%h CO=%b, expected P=%h CO=%b", bb.P, bb.CARRYOUT, e.p, e.co);
    else n_pass++;
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (bb.CARRYOUT !== 1'b0 || bb.CARRYOUTF !== 1'b0 || bb.P !== 48'h0)
      $display("FAIL carry_clear: P=%h CO=%b, expected P=0 CO=0", bb.P, bb.CARRYOUT);
    else n_pass++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_carry_wrap;
    exp_t e;
    bb.OPMODE = 8'h2F; bb.DAB = 48'hFFFF_FFFF_FFFF; bb.C = 48'h0;
    q_byp.push_back('{p: 48'h0, co: 1'b1});
    tick();
    e = q_byp.pop_front();
    n_checks++;
    if (bb.P !== e.p || bb.CARRYOUT !== e.co)
      $display("FAIL carry_wrap: P=%h CO=%b, expected P=%h CO=%b", bb.P, bb.CARRYOUT, e.p, e.co);
    else n_pass++;
  endtask

  task automatic test_feedback_double;
    exp_t e;
    logic [7:0] ops [3];
    logic [47:0] pm;
    logic [48:0] r;
    ops[0] = 8'h0C; ops[1] = 8'h2A; ops[2] = 8'h2A;
    bb.C = 48'd7;
    pm = 48'h0;
    for (int i = 0; i < 3; i++) begin
      bb.OPMODE = ops[i];
      r = model(ops[i], bb.M, bb.C, bb.DAB, bb.PCIN, pm, ops[i][5]);
      pm = r[47:0];
      q_byp.push_back('{p: r[47:0], co: r[48]});
      tick();
      e = q_byp.pop_front();
      n_checks++;
      if (bb.P !== e.p || bb.CARRYOUT !== e.co)
        $display("FAIL feedback_double[%0d]: P=%h CO=%b, expected P=%h CO=%b",
                 i, bb.P, bb.CARRYOUT, e.p, e.co);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    exp_t e;
    logic [7:0]  op;
    logic [47:0] pm;
    logic [48:0] r;
    pm = 48'h0;
    for (int i = 0; i < 12; i++) begin
      op = (i == 0) ? 8'h0C : 8'($urandom);
      bb.OPMODE = op;
      bb.M    = 36'({$urandom, $urandom});
      bb.C    = 48'({$urandom, $urandom});
      bb.DAB  = 48'({$urandom, $urandom});
      bb.PCIN = 48'({$urandom, $urandom});
      r = model(op, bb.M, bb.C, bb.DAB, bb.PCIN, pm, op[5]);
      pm = r[47:0];
      q_byp.push_back('{p: r[47:0], co: r[48]});
      tick();
      e = q_byp.pop_front();
      n_checks++;
      if (bb.P !== e.p || bb.PCOUT !== e.p || bb.CARRYOUT !== e.co)
        $display("FAIL random[%0d] op=%h: P=%h CO=%b, expected P=%h CO=%b",
                 i, op, bb.P, bb.CARRYOUT, e.p, e.co);
      else n_pass++;
    end
  endtask

  task automatic test_opmode_latency;
    exp_t e;
    rb.OPMODE = 8'h0D; rb.M = 36'd5; rb.C = 48'd10; rb.CARRYIN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        2: begin rb.OPMODE = 8'h01; rb.CARRYIN = 1'b1; end
        4: begin rb.CEOPMODE = 1'b0; rb.CECARRYIN = 1'b0; rb.OPMODE = 8'h2D;
                 rb.CARRYIN = 1'b0; end
        6: begin rb.CEOPMODE = 1'b1; rb.CEP = 1'b0; rb.OPMODE = 8'h0D; end
        7: rb.CEP = 1'b1;
        default: ;
      endcase
      case (i)
        0: q_reg.push_back('{p: 48'd0,  co: 1'b0});
        1, 2: q_reg.push_back('{p: 48'd15, co: 1'b0});
        7: q_reg.push_back('{p: 48'd16, co: 1'b0});
        default: q_reg.push_back('{p: 48'd6, co: 1'b0});
      endcase
      tick();
      e = q_reg.pop_front();
      n_checks++;
      if (rb.P !== e.p || rb.PCOUT !== e.p || rb.CARRYOUT !== e.co)
        $display("FAIL opmode_latency[%0d]: P=%h CO=%b, expected P=%h CO=%b",
                 i, rb.P, rb.CARRYOUT, e.p, e.co);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_add();
    test_accumulate();
    test_subtract();
    test_carry_wrap();
    test_feedback_double();
    test_random();
    test_opmode_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
